// File: rtl/ternary_pkg.sv
// Shared definitions for the ternary matrix-vector multiplier: weight codes,
// FSM states and the saturating narrowing helper.
package ternary_pkg;

    localparam logic [1:0] W_POS = 2'b01;
    localparam logic [1:0] W_NEG = 2'b11;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

    // Clamps a sign-extended accumulator value into the signed range of bw bits.
    function automatic logic signed [63:0] sat_narrow(input logic signed [63:0] v, input int bw);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (bw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (bw - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/ternary_lane_mac.sv
// Combinational LANES-term ternary dot product for one output column.
module ternary_lane_mac
    import ternary_pkg::*;
#(
    parameter int LANES     = 2,
    parameter int BIT_WIDTH = 8,
    parameter int ACC_WIDTH = 12
) (
    input  logic [LANES*BIT_WIDTH-1:0] x,
    input  logic [2*LANES-1:0]         w,
    output logic signed [ACC_WIDTH-1:0] sum
);

    logic signed [ACC_WIDTH-1:0] xe;

    // Sign-extend before negating so that -(-2^(BIT_WIDTH-1)) stays exact.
    always_comb begin
        sum = '0;
        xe  = '0;
        for (int l = 0; l < LANES; l++) begin
            xe = ACC_WIDTH'(signed'(x[l*BIT_WIDTH +: BIT_WIDTH]));
            if (w[2*l +: 2] == W_POS) begin
                sum = sum + xe;
            end else if (w[2*l +: 2] == W_NEG) begin
                sum = sum - xe;
            end
        end
    end

endmodule

// File: rtl/ternary_mvm_stream.sv
// Streaming ternary matrix-vector multiplier with valid/ready on both sides.
// Define TERNARY_MVM_SAT_EN to saturate results instead of wrapping them.
module ternary_mvm_stream
    import ternary_pkg::*;
#(
    parameter int IN_LEN    = 14,
    parameter int OUT_LEN   = 7,
    parameter int BIT_WIDTH = 8,
    parameter int LANES     = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES*BIT_WIDTH-1:0]    in_data,
    input  logic [2*IN_LEN*OUT_LEN-1:0]   w,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BIT_WIDTH-1:0]          out_data,
    output logic [$clog2(OUT_LEN)-1:0]    out_idx,
    output logic                          out_last,
    output logic                          busy
);

    localparam int BEATS     = IN_LEN / LANES;
    localparam int ACC_WIDTH = BIT_WIDTH + $clog2(IN_LEN) + 1;
    localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int IDX_W     = $clog2(OUT_LEN);

    state_t state;
    state_t next_state;
    logic [BEAT_W-1:0] beat_cnt;
    logic [IDX_W-1:0]  next_idx;
    logic              accept;
    logic              last_beat;
    logic              idx_last;

    logic [2*LANES-1:0]          col_w   [OUT_LEN];
    logic signed [ACC_WIDTH-1:0] contrib [OUT_LEN];
    logic signed [ACC_WIDTH-1:0] acc     [OUT_LEN];

    assign accept    = in_valid && in_ready;
    assign last_beat = (beat_cnt == BEAT_W'(BEATS - 1));
    assign idx_last  = (out_idx == IDX_W'(OUT_LEN - 1));

    // Pick out, for each column, the weight codes of the elements in the current beat.
    always_comb begin
        for (int o = 0; o < OUT_LEN; o++) begin
            col_w[o] = '0;
            for (int l = 0; l < LANES; l++) begin
                col_w[o][2*l +: 2] = w[2*((int'(beat_cnt)*LANES + l)*OUT_LEN + o) +: 2];
            end
        end
    end

    for (genvar o = 0; o < OUT_LEN; o++) begin : g_col
        ternary_lane_mac #(
            .LANES     (LANES),
            .BIT_WIDTH (BIT_WIDTH),
            .ACC_WIDTH (ACC_WIDTH)
        ) u_mac (
            .x   (in_data),
            .w   (col_w[o]),
            .sum (contrib[o])
        );
    end

    always_comb begin
        next_state = state;
        next_idx   = out_idx;
        unique case (state)
            IDLE, ACCUM: begin
                if (accept) next_state = last_beat ? DRAIN : ACCUM;
            end
            DRAIN: begin
                if (out_ready) begin
                    if (idx_last) begin
                        next_state = IDLE;
                        next_idx   = '0;
                    end else begin
                        next_idx = out_idx + 1'b1;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Handshake and status outputs are registered from the next-state decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out_idx   <= '0;
            out_last  <= 1'b0;
        end else begin
            state     <= next_state;
            in_ready  <= (next_state != DRAIN);
            out_valid <= (next_state == DRAIN);
            busy      <= (next_state != IDLE);
            out_idx   <= next_idx;
            out_last  <= (next_state == DRAIN) && (next_idx == IDX_W'(OUT_LEN - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
            for (int o = 0; o < OUT_LEN; o++) acc[o] <= '0;
        end else if (accept) begin
            beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
            for (int o = 0; o < OUT_LEN; o++) begin
                if (beat_cnt == '0) acc[o] <= contrib[o];
                else                acc[o] <= acc[o] + contrib[o];
            end
        end
    end

`ifdef TERNARY_MVM_SAT_EN
    assign out_data = BIT_WIDTH'(sat_narrow(64'(acc[out_idx]), BIT_WIDTH));
`else
    assign out_data = acc[out_idx][BIT_WIDTH-1:0];
`endif

endmodule

// File: tb/tb_ternary_mvm_stream.sv
// Self-checking bench for ternary_mvm_stream (IN_LEN=4, OUT_LEN=2, LANES=2, BIT_WIDTH=8).
module tb_ternary_mvm_stream;

    localparam int IN_LEN  = 4;
    localparam int OUT_LEN = 2;
    localparam int BW      = 8;
    localparam int LANES   = 2;
    localparam int WW      = 2*IN_LEN*OUT_LEN;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [LANES*BW-1:0] in_data;
    logic [WW-1:0]     w;
    logic              out_valid;
    logic              out_ready;
    logic [BW-1:0]     out_data;
    logic [0:0]        out_idx;
    logic              out_last;
    logic              busy;

    int checks   = 0;
    int failures = 0;
    int model [OUT_LEN];

    always #5 clk = ~clk;

    ternary_mvm_stream #(
        .IN_LEN    (IN_LEN),
        .OUT_LEN   (OUT_LEN),
        .BIT_WIDTH (BW),
        .LANES     (LANES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .w         (w),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy)
    );

    function automatic int wval(input logic [1:0] c);
        if (c == 2'b01) return 1;
        if (c == 2'b11) return -1;
        return 0;
    endfunction

    function automatic logic [BW-1:0] narrow_model(input int v);
`ifdef TERNARY_MVM_SAT_EN
        if (v > 127)  return 8'd127;
        if (v < -128) return 8'h80;
        return 8'(v);
`else
        return 8'(v);
`endif
    endfunction

    task automatic send_beat(input int b, input int x0, input int x1, input logic [WW-1:0] wword);
        int xl;
        int i;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = {8'(x1), 8'(x0)};
        w        = wword;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL beat_ready b=%0d got=%b want=1", b, in_ready);
        end
        if (b == 0) for (int o = 0; o < OUT_LEN; o++) model[o] = 0;
        for (int l = 0; l < LANES; l++) begin
            i  = b*LANES + l;
            xl = (l == 0) ? x0 : x1;
            for (int o = 0; o < OUT_LEN; o++)
                model[o] += wval(wword[2*(i*OUT_LEN + o) +: 2]) * xl;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send_vector(input int x0, input int x1, input int x2, input int x3,
                               input logic [WW-1:0] w0, input logic [WW-1:0] w1);
        send_beat(0, x0, x1, w0);
        send_beat(1, x2, x3, w1);
    endtask

    // Drains all results; optionally stalls on index 0 while poking in_valid.
    task automatic drain_check(input string name, input int stall);
        logic [BW-1:0] held;
        for (int o = 0; o < OUT_LEN; o++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_idx !== 1'(o) || out_last !== (o == OUT_LEN-1) ||
                in_ready !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("[TB] FAIL %s_ctrl%0d got v=%b i=%0d l=%b r=%b b=%b want v=1 i=%0d l=%b r=0 b=1",
                         name, o, out_valid, out_idx, out_last, in_ready, busy, o, (o == OUT_LEN-1));
            end
            checks++;
            if (out_data !== narrow_model(model[o])) begin
                failures++;
                $display("[TB] FAIL %s_data%0d got=%h want=%h", name, o, out_data, narrow_model(model[o]));
            end
            if (o == 0 && stall > 0) begin
                held = out_data;
                for (int s = 0; s < stall; s++) begin
                    in_valid = 1'b1;
                    in_data  = 16'h7F7F;
                    w        = 16'h5555;
                    @(negedge clk);
                    in_valid = 1'b0;
                    checks++;
                    if (out_valid !== 1'b1 || out_idx !== 1'b0 || out_data !== held || in_ready !== 1'b0) begin
                        failures++;
                        $display("[TB] FAIL %s_hold%0d got v=%b i=%0d d=%h r=%b want v=1 i=0 d=%h r=0",
                                 name, s, out_valid, out_idx, out_data, in_ready, held);
                    end
                end
            end
            out_ready = 1'b1;
            @(posedge clk);
            #1 out_ready = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_idx !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s_idle got v=%b r=%b b=%b i=%0d want v=0 r=1 b=0 i=0",
                     name, out_valid, in_ready, busy, out_idx);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; w = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_idx !== 1'b0 ||
            out_last !== 1'b0 || out_data !== 8'h00) begin
            failures++;
            $display("[TB] FAIL reset got r=%b v=%b b=%b i=%0d l=%b d=%h want r=1 v=0 b=0 i=0 l=0 d=00",
                     in_ready, out_valid, busy, out_idx, out_last, out_data);
        end
    endtask

    task automatic test_basic();
        send_vector(1, 2, 3, 4, 16'hDDDD, 16'hDDDD);
        drain_check("basic", 0);
    endtask

    task automatic test_saturation();
        send_vector(127, 127, 127, 127, 16'h5555, 16'h5555);
        drain_check("sat_pos", 0);
        send_vector(-128, -128, -128, -128, 16'h5555, 16'h5555);
        drain_check("sat_neg", 0);
    endtask

    task automatic test_edge_codes();
        send_vector(9, -7, 100, -100, 16'hAAAA, 16'hAAAA);
        drain_check("code10", 0);
        send_vector(-128, 5, 7, 9, 16'hAAAB, 16'hAAAA);
        drain_check("neg_min", 0);
    endtask

    task automatic test_backpressure();
        send_vector(3, -5, 11, 20, 16'h9D71, 16'h37C5);
        drain_check("bp", 3);
        send_vector(1, 2, 3, 4, 16'h5555, 16'h5555);
        drain_check("bp_next", 0);
    endtask

    task automatic test_reset_mid_accum();
        send_beat(0, 50, 60, 16'h5555);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL mid_rst got v=%b b=%b r=%b want v=0 b=0 r=1", out_valid, busy, in_ready);
        end
        send_vector(1, 1, 1, 1, 16'h5555, 16'h5555);
        drain_check("mid_rst", 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            send_vector($urandom_range(255) - 128, $urandom_range(255) - 128,
                        $urandom_range(255) - 128, $urandom_range(255) - 128,
                        WW'($urandom), WW'($urandom));
            drain_check("rand", (n % 3 == 0) ? int'($urandom_range(4, 1)) : 0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_edge_codes();
        test_backpressure();
        test_reset_mid_accum();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ternary_mvm_stream.md
# ternary_mvm_stream

Parametrised, streaming ternary matrix-vector multiplier: it accumulates an IN_LEN-element signed input vector, LANES elements per beat, against a flat 2-bit ternary weight array. It then drains OUT_LEN results one per handshake. It is the next-generation datapath core between the tile's input shifter and output serializer. It adds valid/ready flow control, a wide accumulator, lane-parallel input, and optional output saturation.

## Interface
- IN_LEN, 14, input vector length; must be a multiple of LANES
- OUT_LEN, 7, output vector length
- BIT_WIDTH, 8, signed element width, in and out
- LANES, 2, input elements consumed per beat; BEATS = IN_LEN/LANES (localparam)
- ACC_WIDTH (localparam), BIT_WIDTH + $clog2(IN_LEN) + 1
- clk  in  1  sole clock, rising edge
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_data  in  LANES*BIT_WIDTH  lane l at bits [l*BIT_WIDTH +: BIT_WIDTH], two's complement
- w  in  2*IN_LEN*OUT_LEN  weight(i,o) at bits [2*(i*OUT_LEN+o) +: 2]
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid && out_ready
- out_data  out  BIT_WIDTH  result element
- out_idx  out  $clog2(OUT_LEN)  index of out_data
- out_last  out  1  high with out_valid on index OUT_LEN-1
- busy  out  1  high in ACCUM or DRAIN

## Operation
- Weight code: 2'b01 = +1, 2'b11 = -1, 2'b00 and 2'b10 = 0.
- Input element i = beat*LANES + lane. Weights are sampled on the cycle that beat is accepted. A change to w mid-vector affects only later beats.
- Per accepted beat, for every o: acc[o] <= base + sum over lanes of (w(i,o) * x_lane), all signed at ACC_WIDTH. base = 0 on beat 0, otherwise acc[o]. Negation of -2^(BIT_WIDTH-1) is exact at ACC_WIDTH.
- FSM IDLE: in_ready=1, out_valid=0. On an accepted beat, go to ACCUM, or to DRAIN if BEATS==1.
- FSM ACCUM: in_ready=1. Beat counter increments per accepted beat. The accepted beat BEATS-1 moves the FSM to DRAIN. No beat means hold.
- FSM DRAIN: in_ready=0, out_valid=1, out_data = narrow(acc[out_idx]). On out_ready, out_idx increments. On out_ready at OUT_LEN-1, go to IDLE with out_idx=0.
- in_valid during DRAIN is ignored: not accepted, no effect on acc.
- narrow(): see Configuration.
- Reset values: state IDLE, in_ready=1, out_valid=0, out_idx=0, out_last=0, busy=0, all acc=0, so out_data=0. Beat counter is 0.
- rst at any point, including mid-ACCUM or mid-DRAIN, discards the partial vector and pending results with no output.

## Timing
- Accepted beats may be back-to-back, one per cycle.
- out_valid rises the cycle after the last beat is accepted.
- Minimum period per vector is BEATS + OUT_LEN cycles, with no overlap between vectors.
- After rst is deasserted, the first beat can be accepted on the very next edge.
- out_data and out_idx hold stable while out_valid && !out_ready.
- All outputs come from registers, except out_data, which is combinational from acc and out_idx.

## Configuration
- TERNARY_MVM_SAT_EN defined: narrow() saturates to [-2^(BIT_WIDTH-1), 2^(BIT_WIDTH-1)-1].
- TERNARY_MVM_SAT_EN undefined: narrow() takes the low BIT_WIDTH bits, i.e. wrap-around.

## Structure
- Shared package ternary_pkg holds:
  - weight code constants W_POS=2'b01, W_NEG=2'b11;
  - FSM state enum {IDLE, ACCUM, DRAIN};
  - a sat_narrow function.
- One sub-module, ternary_lane_mac. It is combinational and computes one output column's LANES-term signed contribution. It is instantiated OUT_LEN times.

## Test plan
All scenarios use IN_LEN=4, OUT_LEN=2, LANES=2, BIT_WIDTH=8 unless stated.
- Reset: hold rst 2 cycles, then release -> in_ready=1, out_valid=0, busy=0, out_idx=0.
- Basic: column 0 all +1, column 1 all -1, x=[1,2,3,4] in 2 beats -> out_valid on the next cycle. Results are idx0=10 then idx1=-10, with out_last on idx1.
- Saturation: all +1, x all 127 gives 508. SAT_EN -> 127, otherwise 0xFC. With x all -128 (-512): SAT_EN -> -128, otherwise 0x00.
- Edge codes: weight 2'b10 gives 0. Weight -1 times x=-128 in a single lane, others 0, gives +128: SAT_EN -> 127, otherwise 0x80.
- Backpressure: out_ready low 3 cycles in DRAIN -> out_data/out_idx held, in_ready=0. in_valid pulses in that window are not accepted, and the next vector is unaffected.
- Reset mid-ACCUM: reset after beat 0, then send x=[1,1,1,1] with all +1 -> result 4 in both columns, no residue from the aborted vector.
